// File: rtl/csa_bist_pkg.sv
// Shared types for the carry-select adder BIST / reconfiguration controller.
// Contents: controller state enum, per-block chain-select codes, and the
// helper that turns a block's two fault bits into its select code.
package csa_bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    ALLOC = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_C0   = 2'b01;
  localparam logic [1:0] SEL_C1   = 2'b10;
  localparam logic [1:0] SEL_BOTH = 2'b11;

  // Select code replacing every faulty chain of one block with a spare.
  function automatic logic [1:0] sel_code(input logic f0, input logic f1);
    case ({f1, f0})
      2'b01:   return SEL_C0;
      2'b10:   return SEL_C1;
      2'b11:   return SEL_BOTH;
      default: return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/csa_bist_golden_dly.sv
// Delays {valid, golden0, golden1} by LAT cycles so the expected values line
// up with the adder's res0/res1 for the same vector. LAT=0 is a pass-through.
// Ports: clk, init_n (async active-low), valid/gold0/gold1 (issue side),
//        aligned_valid/aligned0/aligned1 (compare side).
module csa_bist_golden_dly #(
  parameter int unsigned BW  = 4,
  parameter int unsigned LAT = 1
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic        valid,
  input  logic [BW:0] gold0,
  input  logic [BW:0] gold1,
  output logic        aligned_valid,
  output logic [BW:0] aligned0,
  output logic [BW:0] aligned1
);

  localparam int unsigned W = 2 * (BW + 1) + 1;

  logic [W-1:0] head;
  logic [W-1:0] tail;

  assign head = {valid, gold0, gold1};

  generate
    if (LAT == 0) begin : g_pass
      assign tail = head;
    end else begin : g_pipe
      logic [W-1:0] stage [LAT];

      // Reset empties the pipe so no in-flight compare survives an abort.
      always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
          for (int unsigned i = 0; i < LAT; i++) stage[i] <= '0;
        end else begin
          stage[0] <= head;
          for (int unsigned i = 1; i < LAT; i++) stage[i] <= stage[i-1];
        end
      end

      assign tail = stage[LAT-1];
    end
  endgenerate

  assign {aligned_valid, aligned0, aligned1} = tail;

endmodule

// File: rtl/csa_bist_reconfig.sv
// BIST and spare-chain allocator for an N-block dual-chain carry-select adder.
// Sweeps every {b,a} operand pair, compares each block's cin=0/cin=1 chain
// against a golden sum, keeps sticky per-chain fault maps, then hands out up
// to SPARES spare chains block by block.
// Ports: clk, init_n (async active-low), start; test/test_data drive the
//        adder; res0/res1 are the per-block chain results; fault0/fault1,
//        sel, fail are the results; busy/done report progress.
module csa_bist_reconfig
  import csa_bist_pkg::*;
#(
  parameter int unsigned BLOCKS = 4,
  parameter int unsigned BW     = 4,
  parameter int unsigned LAT    = 1,
  parameter int unsigned SPARES = 2
) (
  input  logic                     clk,
  input  logic                     init_n,
  input  logic                     start,
  output logic                     test,
  output logic [2*BW-1:0]          test_data,
  input  logic [BLOCKS*(BW+1)-1:0] res0,
  input  logic [BLOCKS*(BW+1)-1:0] res1,
  output logic [BLOCKS-1:0]        fault0,
  output logic [BLOCKS-1:0]        fault1,
  output logic [2*BLOCKS-1:0]      sel,
  output logic                     busy,
  output logic                     done,
  output logic                     fail
);

  localparam int unsigned TW = 2 * BW;
  localparam int unsigned RW = BW + 1;
  localparam int unsigned CW = $clog2(LAT + BLOCKS + 1);
  localparam int unsigned UW = $clog2(SPARES + 3) + 1;
  localparam logic [TW-1:0] PRE_LAST = {TW{1'b1}} - TW'(1);

  state_t state, state_nx;

  logic [CW-1:0]       cnt, cnt_nx;
  logic [UW-1:0]       used, used_nx, need;
  logic                issue, issue_nx;
  logic                test_nx, busy_nx, done_nx, fail_nx;
  logic [TW-1:0]       data_nx;
  logic [BLOCKS-1:0]   f0_nx, f1_nx, miss0, miss1;
  logic [2*BLOCKS-1:0] sel_nx;
  logic [RW-1:0]       gold0, gold1, chk0, chk1;
  logic                chk_valid;

  // Golden results of the vector currently on test_data.
  assign gold0 = RW'(test_data[BW-1:0]) + RW'(test_data[TW-1:BW]);
  assign gold1 = gold0 + RW'(1);

  csa_bist_golden_dly #(.BW(BW), .LAT(LAT)) u_dly (
    .clk           (clk),
    .init_n        (init_n),
    .valid         (issue),
    .gold0         (gold0),
    .gold1         (gold1),
    .aligned_valid (chk_valid),
    .aligned0      (chk0),
    .aligned1      (chk1)
  );

  // Per-block chain comparators, carry bit included.
  always_comb begin
    miss0 = '0;
    miss1 = '0;
    for (int unsigned b = 0; b < BLOCKS; b++) begin
      miss0[b] = chk_valid && (res0[b*RW +: RW] != chk0);
      miss1[b] = chk_valid && (res1[b*RW +: RW] != chk1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (test_data == PRE_LAST) state_nx = DRAIN;
      DRAIN:   if (cnt == CW'(LAT)) state_nx = ALLOC;
      ALLOC:   if (cnt == CW'(BLOCKS - 1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of all registered outputs and datapath state.
  always_comb begin
    test_nx  = test;
    data_nx  = test_data;
    issue_nx = 1'b0;
    cnt_nx   = cnt;
    busy_nx  = busy;
    done_nx  = 1'b0;
    f0_nx    = fault0 | miss0;
    f1_nx    = fault1 | miss1;
    sel_nx   = sel;
    fail_nx  = fail;
    used_nx  = used;
    need     = '0;
    case (state)
      IDLE: begin
        busy_nx = 1'b0;
        test_nx = 1'b0;
        if (start) begin
          test_nx  = 1'b1;
          busy_nx  = 1'b1;
          data_nx  = '0;
          issue_nx = 1'b1;
          cnt_nx   = '0;
          f0_nx    = '0;
          f1_nx    = '0;
          sel_nx   = '0;
          fail_nx  = 1'b0;
          used_nx  = '0;
        end
      end
      RUN: begin
        data_nx  = test_data + TW'(1);
        issue_nx = 1'b1;
        cnt_nx   = '0;
      end
      DRAIN: begin
        cnt_nx = cnt + CW'(1);
        if (cnt == CW'(LAT)) begin
          test_nx = 1'b0;
          data_nx = '0;
          cnt_nx  = '0;
        end
      end
      ALLOC: begin
        cnt_nx = cnt + CW'(1);
        // A block that does not fit gets no spare, but later blocks still try.
        for (int unsigned b = 0; b < BLOCKS; b++) begin
          if (cnt == CW'(b)) begin
            need = UW'(fault0[b]) + UW'(fault1[b]);
            if (used + need <= UW'(SPARES)) begin
              sel_nx[2*b +: 2] = sel_code(fault0[b], fault1[b]);
              used_nx          = used + need;
            end else begin
              sel_nx[2*b +: 2] = SEL_NONE;
              fail_nx          = 1'b1;
            end
          end
        end
      end
      DONE:    done_nx = 1'b1;
      default: ;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      test      <= 1'b0;
      test_data <= '0;
      issue     <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault0    <= '0;
      fault1    <= '0;
      sel       <= '0;
      fail      <= 1'b0;
      used      <= '0;
    end else begin
      test      <= test_nx;
      test_data <= data_nx;
      issue     <= issue_nx;
      cnt       <= cnt_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      fault0    <= f0_nx;
      fault1    <= f1_nx;
      sel       <= sel_nx;
      fail      <= fail_nx;
      used      <= used_nx;
    end
  end

endmodule

// File: tb/tb_csa_bist_reconfig.sv
// Bench for csa_bist_reconfig: a faultable behavioural adder (one-cycle
// result latency), a reference model that derives fault maps and spare
// allocation directly from the injected faults, and a done-triggered
// scoreboard monitor.
module tb_csa_bist_reconfig;

  localparam int unsigned BLOCKS  = 4;
  localparam int unsigned BW      = 4;
  localparam int unsigned LAT     = 1;
  localparam int unsigned SPARES  = 2;
  localparam int unsigned TW      = 2 * BW;
  localparam int unsigned RW      = BW + 1;
  localparam int unsigned NV      = 1 << TW;
  localparam int unsigned RUN_LEN = NV + LAT + 1 + BLOCKS;

  typedef struct packed {
    logic [BLOCKS-1:0]   f0;
    logic [BLOCKS-1:0]   f1;
    logic [2*BLOCKS-1:0] sel;
    logic                fail;
    int unsigned         due;
  } exp_t;

  logic clk = 1'b0;
  logic init_n = 1'b1;
  logic start = 1'b0;
  logic test, busy, done, fail;
  logic [TW-1:0] test_data;
  logic [BLOCKS*RW-1:0] res0 = '0;
  logic [BLOCKS*RW-1:0] res1 = '0;
  logic [BLOCKS-1:0] fault0, fault1;
  logic [2*BLOCKS-1:0] sel;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;
  exp_t sb[$];

  // Stuck-at faults per block and chain: masked bits forced to the value bits.
  logic [RW-1:0] fm0 [BLOCKS];
  logic [RW-1:0] fv0 [BLOCKS];
  logic [RW-1:0] fm1 [BLOCKS];
  logic [RW-1:0] fv1 [BLOCKS];

  csa_bist_reconfig #(
    .BLOCKS(BLOCKS), .BW(BW), .LAT(LAT), .SPARES(SPARES)
  ) dut (
    .clk       (clk),
    .init_n    (init_n),
    .start     (start),
    .test      (test),
    .test_data (test_data),
    .res0      (res0),
    .res1      (res1),
    .fault0    (fault0),
    .fault1    (fault1),
    .sel       (sel),
    .busy      (busy),
    .done      (done),
    .fail      (fail)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [RW-1:0] chain(input int unsigned blk, input int unsigned cin,
                                          input int unsigned a, input int unsigned b);
    logic [RW-1:0] t;
    t = RW'(a + b + cin);
    if (cin != 0) return (t & ~fm1[blk]) | (fv1[blk] & fm1[blk]);
    return (t & ~fm0[blk]) | (fv0[blk] & fm0[blk]);
  endfunction

  function automatic logic [BLOCKS*RW-1:0] adder(input int unsigned cin, input logic [TW-1:0] v);
    logic [BLOCKS*RW-1:0] r;
    int unsigned a, b;
    a = int'(v) % (1 << BW);
    b = int'(v) >> BW;
    r = '0;
    for (int unsigned k = 0; k < BLOCKS; k++) r[k*RW +: RW] = chain(k, cin, a, b);
    return r;
  endfunction

  // Adder under test: results appear one cycle after test_data.
  always @(posedge clk) begin
    res0 <= adder(0, test_data);
    res1 <= adder(1, test_data);
  end

  // Reference: a chain is faulty if any operand pair gives a wrong sum;
  // spares are then granted in block order while they last.
  function automatic exp_t model(input int unsigned due);
    exp_t e;
    int unsigned used, need, a, b;
    e = '0;
    e.due = due;
    for (int unsigned k = 0; k < BLOCKS; k++) begin
      for (int unsigned v = 0; v < NV; v++) begin
        a = v % (1 << BW);
        b = v >> BW;
        if (chain(k, 0, a, b) != RW'(a + b))     e.f0[k] = 1'b1;
        if (chain(k, 1, a, b) != RW'(a + b + 1)) e.f1[k] = 1'b1;
      end
    end
    used = 0;
    for (int unsigned k = 0; k < BLOCKS; k++) begin
      need = int'(e.f0[k]) + int'(e.f1[k]);
      if (used + need <= SPARES) begin
        e.sel[2*k +: 2] = {e.f1[k], e.f0[k]};
        used += need;
      end else begin
        e.fail = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  task automatic clear_faults();
    for (int unsigned k = 0; k < BLOCKS; k++) begin
      fm0[k] = '0; fv0[k] = '0; fm1[k] = '0; fv1[k] = '0;
    end
  endtask

  task automatic inject(input int unsigned blk, input int unsigned ch,
                        input int unsigned bitn, input int unsigned val);
    logic [RW-1:0] m;
    m = RW'(1 << bitn);
    if (ch == 0) begin
      fm0[blk] = fm0[blk] | m;
      fv0[blk] = (val != 0) ? (fv0[blk] | m) : (fv0[blk] & ~m);
    end else begin
      fm1[blk] = fm1[blk] | m;
      fv1[blk] = (val != 0) ? (fv1[blk] | m) : (fv1[blk] & ~m);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (init_n && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("fault0", fault0, e.f0);
        check("fault1", fault1, e.f1);
        check("sel", sel, e.sel);
        check("fail", fail, e.fail);
        check("done_latency", cyc, e.due);
      end
    end
  end

  task automatic run(input bit hold);
    exp_t e;
    int unsigned n;
    bit got;
    @(negedge clk);
    e = model(cyc + 1 + RUN_LEN);
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    check("start_clears", {fail, sel, fault1, fault0}, '0);
    check("start_outputs", {test, busy, done, test_data}, {3'b110, TW'(0)});
    got = 1'b0;
    n = 0;
    while (!got && n < RUN_LEN + 20) begin
      @(negedge clk);
      n++;
      if (n == 100) check("mid_run", {test, busy, test_data}, {2'b11, TW'(100)});
      if (n == NV - 1 + LAT) check("last_drain_test", test, 1);
      if (n == NV + LAT) check("alloc_test", test, 0);
      if (done) got = 1'b1;
    end
    start = 1'b0;
    if (!got) begin
      check("done_timeout", 0, 1);
      void'(sb.pop_back());
    end else begin
      @(negedge clk);
      @(negedge clk);
      check("after_done", {busy, done, test}, 3'b000);
    end
  endtask

  task automatic abort_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    check("pre_abort_busy", {busy, test}, 2'b11);
    check("pre_abort_faults", |{fault0, fault1}, 1);
    #2 init_n = 1'b0;
    #1;
    check("abort_outputs", {test, busy, done, fail, test_data, fault0, fault1, sel}, '0);
    @(negedge clk);
    init_n = 1'b1;
  endtask

  initial begin
    int unsigned nf;
    clear_faults();
    #2 init_n = 1'b0;
    #1;
    check("reset_outputs", {test, busy, done, fail, test_data, fault0, fault1, sel}, '0);
    repeat (2) @(negedge clk);
    init_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outputs", {test, busy, done, fail, fault0, fault1, sel}, '0);

    // Fault-free adder.
    run(1'b0);
    check("clean_result", {fail, sel, fault1, fault0}, '0);

    // Block 2 chain0 sum bit 1 stuck-at-0.
    clear_faults();
    inject(2, 0, 1, 0);
    run(1'b0);
    check("single_fault0", fault0, 4'b0100);
    check("single_sel_b2", sel[5:4], 2'b01);
    check("single_fail", fail, 0);

    // Block 1 chain1 carry stuck-at-1, block 3 chain0 bit 0 stuck-at-1.
    clear_faults();
    inject(1, 1, BW, 1);
    inject(3, 0, 0, 1);
    run(1'b0);
    check("double_sel_b1", sel[3:2], 2'b10);
    check("double_sel_b3", sel[7:6], 2'b01);
    check("double_fail", fail, 0);

    // Three faulty chains, two spares: the third block misses out.
    clear_faults();
    inject(0, 0, 0, 1);
    inject(1, 1, 0, 1);
    inject(2, 0, 0, 1);
    run(1'b0);
    check("triple_sel_b0", sel[1:0], 2'b01);
    check("triple_sel_b1", sel[3:2], 2'b10);
    check("triple_sel_b2", sel[5:4], 2'b00);
    check("triple_fail", fail, 1);

    // Reset mid-run, then a fresh run on a clean adder.
    abort_run();
    clear_faults();
    run(1'b0);

    // Start held high for the whole run; then a start after DONE clears results.
    inject(3, 1, 2, 0);
    run(1'b1);
    repeat (10) @(negedge clk);
    check("held_start_idle", busy, 0);
    clear_faults();
    run(1'b0);

    // Randomized fault sets.
    for (int r = 0; r < 6; r++) begin
      clear_faults();
      nf = $urandom_range(0, 3);
      for (int unsigned j = 0; j < nf; j++)
        inject($urandom_range(0, BLOCKS - 1), $urandom_range(0, 1),
               $urandom_range(0, BW), $urandom_range(0, 1));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run(1'b0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
